// File: rtl/mrr_pathway_arbiter.sv
// Packet-atomic round-robin merge of NUM_PATHWAYS 32-bit AXI-stream
// pathways onto one output stream. Each packet is preceded by a header
// word {8'hA5, 6'b0, pathway[1:0], seq_num}. A stall watchdog closes a
// stuck packet with {16'hDEAD, pathway} (tlast=1) and drains the rest of
// that input packet so the other pathways keep flowing.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   timeout_len           stall limit in cycles (0 disables the watchdog)
//   i_tdata/tvalid/tlast  packed pathway streams (pathway p at [32*(p+1)-1 -: 32])
//   i_tready              per-pathway ready
//   o_tdata/tvalid/tlast  merged stream (one register stage)
//   o_tready              downstream ready
//   grant_idx             current / last granted pathway
//   busy                  high whenever the FSM is not in IDLE
//   seq_num               packets started (wraps)
//   abort_count           watchdog aborts (saturates)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | round-robin scan of i_tvalid from rr_ptr
// HDR   | load header word into the output register
// DATA  | forward beats of the granted pathway, watchdog running
// ABORT | load the DEAD closing word (tlast=1)
// DRAIN | swallow the granted pathway's beats up to its tlast

module mrr_pathway_arbiter #(
   parameter int NUM_PATHWAYS  = 4,
   parameter int IDX_WIDTH     = 2,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [TIMEOUT_WIDTH-1:0]  timeout_len,
   input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
   input  logic [NUM_PATHWAYS-1:0]   i_tvalid,
   input  logic [NUM_PATHWAYS-1:0]   i_tlast,
   output logic [NUM_PATHWAYS-1:0]   i_tready,
   output logic [31:0]               o_tdata,
   output logic                      o_tvalid,
   output logic                      o_tlast,
   input  logic                      o_tready,
   output logic [IDX_WIDTH-1:0]      grant_idx,
   output logic                      busy,
   output logic [15:0]               seq_num,
   output logic [15:0]               abort_count
);

   typedef enum logic [2:0] {IDLE, HDR, DATA, ABORT, DRAIN} state_t;

   localparam logic [IDX_WIDTH:0]   NP_W     = (IDX_WIDTH+1)'(NUM_PATHWAYS);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PATHWAYS-1);

   state_t                   state, state_n;
   logic [IDX_WIDTH-1:0]     rr_ptr, rr_n, grant_n, winner, next_rr;
   logic [15:0]              seq_n, abort_n;
   logic [TIMEOUT_WIDTH-1:0] wd_cnt, wd_n;
   logic [31:0]              odata_n;
   logic                     ovalid_n, olast_n;
   logic                     ld, found, expired;
   logic [2*NUM_PATHWAYS-1:0] rot;
   logic [IDX_WIDTH:0]       sum;
   logic [31:0]              pdata [NUM_PATHWAYS];

   for (genvar p = 0; p < NUM_PATHWAYS; p++) begin : g_unpack
      assign pdata[p] = i_tdata[32*(p+1)-1 -: 32];
   end

   assign ld      = !o_tvalid || o_tready;
   assign busy    = (state != IDLE);
   assign next_rr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
   assign expired = (timeout_len != '0) && (wd_cnt >= timeout_len);

   // Rotate valids so bit 0 is rr_ptr; descending loop leaves the
   // lowest rotated position (the first one from rr_ptr) as winner.
   always_comb begin
      rot    = {i_tvalid, i_tvalid} >> rr_ptr;
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      for (int i = NUM_PATHWAYS-1; i >= 0; i--) begin
         if (rot[i]) begin
            found  = 1'b1;
            sum    = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(i);
            winner = (sum >= NP_W) ? IDX_WIDTH'(sum - NP_W) : IDX_WIDTH'(sum);
         end
      end
   end

   always_comb begin
      state_n  = state;
      grant_n  = grant_idx;
      rr_n     = rr_ptr;
      seq_n    = seq_num;
      abort_n  = abort_count;
      wd_n     = wd_cnt;
      odata_n  = o_tdata;
      olast_n  = o_tlast;
      ovalid_n = o_tvalid;
      i_tready = '0;
      // A loadable register empties unless something is loaded below.
      if (ld) ovalid_n = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant_n = winner;
               state_n = HDR;
            end
         end
         HDR: begin
            wd_n = '0;
            if (ld) begin
               odata_n  = {8'hA5, 6'b0, 2'(grant_idx), seq_num};
               olast_n  = 1'b0;
               ovalid_n = 1'b1;
               seq_n    = seq_num + 1'b1;
               state_n  = DATA;
            end
         end
         DATA: begin
            i_tready[grant_idx] = ld;
            // An input beat takes priority over a simultaneous expiry.
            if (ld && i_tvalid[grant_idx]) begin
               odata_n  = pdata[grant_idx];
               olast_n  = i_tlast[grant_idx];
               ovalid_n = 1'b1;
               wd_n     = '0;
               if (i_tlast[grant_idx]) begin
                  state_n = IDLE;
                  rr_n    = next_rr;
               end
            end else if (expired) begin
               state_n = ABORT;
            end else if (ld) begin
               wd_n = wd_cnt + 1'b1;
            end
         end
         ABORT: begin
            if (ld) begin
               odata_n  = {16'hDEAD, 16'(grant_idx)};
               olast_n  = 1'b1;
               ovalid_n = 1'b1;
               if (abort_count != 16'hFFFF) abort_n = abort_count + 1'b1;
               state_n  = DRAIN;
            end
         end
         DRAIN: begin
            i_tready[grant_idx] = 1'b1;
            if (i_tvalid[grant_idx] && i_tlast[grant_idx]) begin
               state_n = IDLE;
               rr_n    = next_rr;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_idx   <= '0;
         seq_num     <= '0;
         abort_count <= '0;
         wd_cnt      <= '0;
         o_tdata     <= '0;
         o_tvalid    <= 1'b0;
         o_tlast     <= 1'b0;
      end else begin
         state       <= state_n;
         rr_ptr      <= rr_n;
         grant_idx   <= grant_n;
         seq_num     <= seq_n;
         abort_count <= abort_n;
         wd_cnt      <= wd_n;
         o_tdata     <= odata_n;
         o_tvalid    <= ovalid_n;
         o_tlast     <= olast_n;
      end
   end

endmodule

// File: doc/mrr_pathway_arbiter.md
Name: mrr_pathway_arbiter

Overview:
Merges the per-pathway 32-bit decoded packet streams from the NUM_DECODE_PATHWAYS loopback/decode pathways onto one AXI-stream toward the host. Packet-atomic round-robin arbitration: prepends a header word identifying the source pathway and a sequence number. A stall watchdog aborts a stuck pathway so that one pathway cannot block the others.

Parameters:
NUM_PATHWAYS, 4, number of input streams; equals NUM_DECODE_PATHWAYS.
IDX_WIDTH, 2, width of the pathway index; equals clog2(NUM_PATHWAYS), minimum 1.
TIMEOUT_WIDTH, 16, width of the stall watchdog counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
timeout_len  in  TIMEOUT_WIDTH  stall limit in cycles; 0 disables the watchdog
i_tdata  in  32*NUM_PATHWAYS  packed pathway data; pathway p is at [32*(p+1)-1 -: 32]
i_tvalid  in  NUM_PATHWAYS  per-pathway valid
i_tlast  in  NUM_PATHWAYS  per-pathway end-of-packet
i_tready  out  NUM_PATHWAYS  per-pathway ready
o_tdata  out  32  merged data
o_tvalid  out  1  merged valid
o_tlast  out  1  merged end-of-packet
o_tready  in  1  downstream ready
grant_idx  out  IDX_WIDTH  currently or last granted pathway
busy  out  1  high in any state other than IDLE
seq_num  out  16  count of packets started
abort_count  out  16  count of watchdog aborts

Behaviour:
- Reset (async, immediate) clears all outputs and registers to 0:
  - o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0, grant_idx=0, busy=0, seq_num=0, abort_count=0.
  - State=IDLE, rr_ptr=0.
- Output register: one stage. It loads when (!o_tvalid || o_tready); this condition is "ld". o_tvalid holds with stable data until o_tready.
- States: IDLE, HDR, DATA, ABORT, DRAIN.
- IDLE:
  - Scan i_tvalid starting at rr_ptr, wrapping modulo NUM_PATHWAYS. The first set bit wins.
  - The winning pathway is latched into grant_idx, then go to HDR. With no valid inputs, stay in IDLE.
  - Arbitration takes 1 cycle.
  - i_tready is all-zero in IDLE, HDR, and ABORT.
- HDR: on ld, the output register takes {8'hA5, 6'b0, grant_idx zero-extended to 2 bits, seq_num}, tlast=0. seq_num increments (wraps at 16 bits). Go to DATA.
- DATA:
  - i_tready[grant_idx] = ld; all other ready bits are 0.
  - On an input beat, copy data and tlast into the output register.
  - A beat carrying tlast: go to IDLE and set rr_ptr = grant_idx+1 (wrapping).
  - First data beat appears on o_tdata 1 cycle after the header is accepted, given continuous valid/ready.
- Watchdog:
  - In DATA, a counter resets on every accepted input beat.
  - It increments each cycle that i_tvalid[grant_idx]=0 and the output register is loadable.
  - Output backpressure does not count toward the stall.
  - When the count reaches timeout_len (timeout_len≠0), go to ABORT.
- ABORT:
  - On ld, emit {16'hDEAD, 14'b0, grant_idx} with tlast=1, so the downstream sees a closed packet.
  - abort_count increments, saturating at 16'hFFFF.
  - Go to DRAIN.
- DRAIN:
  - i_tready[grant_idx]=1 unconditionally; beats are discarded and the output is not loaded.
  - On an accepted beat with tlast: go to IDLE, rr_ptr=grant_idx+1.
- The output never carries a partial packet without tlast. The header always precedes data.
- timeout_len changing mid-packet takes effect on the next cycle's compare (compare uses >=).
- The final tlast beat in DATA and a watchdog expiry in the same cycle: the beat wins and there is no abort.
- Pathway valid deasserting while not granted is legal and ignored.
- Widths:
  - All counters wrap except abort_count.
  - rr_ptr wraps to 0 after NUM_PATHWAYS-1, including non-power-of-2 NUM_PATHWAYS.

Test Plan:
- Reset mid-packet: assert rst while in DATA → all outputs are 0 in the same cycle; after release, the first grant goes to pathway 0 with seq_num=0.
- Single packet:
  - Stimulus: pathway 2 sends 3 words, 0x11, 0x22, 0x33 (tlast on 0x33), with o_tready=1.
  - Expected output: 0xA5020000, 0x11, 0x22, 0x33 with tlast on the last word.
  - Afterwards: seq_num=1, busy returns to 0.
- Round robin: all 4 pathways hold 2-word packets continuously → grant order is 0,1,2,3,0; headers carry seq 0..4; no interleaving of words within a packet.
- Backpressure:
  - Stimulus: toggle o_tready 1010… during a 5-word packet.
  - Expected: o_tdata stable while o_tvalid && !o_tready; all 5 words delivered in order; no watchdog abort with timeout_len=2.
- Watchdog:
  - Stimulus: timeout_len=8; pathway 1 sends 1 word without tlast, then stalls for 8 cycles, then later sends 2 words, the second with tlast.
  - Expected: output is header, word, then 0xDEAD0001 with tlast; abort_count=1.
  - The 2 late words are drained and not forwarded; the next grant goes to pathway 2.
- Watchdog disabled: timeout_len=0 and a 100-cycle stall → no abort; the packet completes normally once tlast arrives.
